// File: rtl/riscv_rvalid_stall.sv
// OBI response-phase delay buffer: captures memory responses and releases them
// to the core in order after a fixed or LFSR-derived delay.
module riscv_rvalid_stall #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_stall_i,
  input  logic [31:0]             stall_mode_i,
  input  logic [31:0]             max_stall_i,
  input  logic [31:0]             rvalid_stall_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_err_o,
  output logic [$clog2(DEPTH):0]  outstanding_o,
  output logic                    overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic [31:0]           stamp;
    logic [15:0]           d;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     occ_q, occ_d;
  logic [31:0]     cyc_q, lfsr_q, lfsr_d;
  logic            ovf_q;

  logic            mode_std, mode_rnd, empty, full;
  logic            bypass, push_req, push, pop;
  logic [16:0]     rnd_mod, rnd_rem;
  logic [15:0]     push_d;
  logic [31:0]     age;
  entry_t          head, new_entry;

  // Upper halves of the 32-bit config words carry no meaning here.
  logic unused_hi;
  assign unused_hi = ^{max_stall_i[31:16], rvalid_stall_i[31:16]};

  always_comb begin
    mode_std  = en_stall_i && (stall_mode_i == 32'd1);
    mode_rnd  = en_stall_i && (stall_mode_i == 32'd2);
    rnd_mod   = {1'b0, max_stall_i[15:0]} + 17'd1;
    rnd_rem   = {1'b0, lfsr_q[15:0]} % rnd_mod;
    push_d    = mode_std ? rvalid_stall_i[15:0] :
                mode_rnd ? rnd_rem[15:0] : 16'd0;

    empty     = (occ_q == '0);
    full      = (occ_q == (AW+1)'(DEPTH));
    head      = mem_q[rd_ptr_q];
    // Unsigned subtraction keeps the age correct across counter wrap.
    age       = cyc_q - head.stamp;
    pop       = !empty && (age > {16'd0, head.d});

    bypass    = !en_stall_i && empty && mem_rvalid_i;
    push_req  = mem_rvalid_i && !bypass;
    push      = push_req && (!full || pop);

    new_entry = '{rdata: mem_rdata_i, err: mem_err_i, stamp: cyc_q, d: push_d};

    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
    else if (!push && pop) occ_d = occ_q - (AW+1)'(1);

    lfsr_d = lfsr_q;
    if (push && mode_rnd)
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ ({32{lfsr_q[0]}} & 32'h8020_0003);
  end

  always_comb begin
    core_rvalid_o = bypass || pop;
    core_rdata_o  = '0;
    core_err_o    = 1'b0;
    if (bypass) begin
      core_rdata_o = mem_rdata_i;
      core_err_o   = mem_err_i;
    end else if (pop) begin
      core_rdata_o = head.rdata;
      core_err_o   = head.err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cyc_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      ovf_q    <= 1'b0;
    end else begin
      cyc_q  <= cyc_q + 32'd1;
      occ_q  <= occ_d;
      lfsr_q <= lfsr_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_req && !push) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign outstanding_o = occ_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_riscv_rvalid_stall.sv
// Scoreboard bench for riscv_rvalid_stall: predicts each response's release
// cycle and data, and compares at every core_rvalid_o.
module tb_riscv_rvalid_stall;

  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_stall_i;
  logic [31:0] stall_mode_i, max_stall_i, rvalid_stall_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic [3:0]  outstanding_o;
  logic        overflow_o;

  riscv_rvalid_stall #(.DATA_WIDTH(32), .DEPTH(8), .LFSR_SEED(SEED)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_stall_i(en_stall_i),
    .stall_mode_i(stall_mode_i), .max_stall_i(max_stall_i),
    .rvalid_stall_i(rvalid_stall_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o), .outstanding_o(outstanding_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
    longint      cyc;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  longint cyc = 0;
  longint last_rel = -1;
  logic [31:0] lfsr_m = SEED;
  int     n_chk = 0;
  int     n_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: every release must match the oldest outstanding prediction.
  always @(negedge clk_i) begin
    if (rst_ni && core_rvalid_o) begin
      if (q.size() == 0) chk("spurious_rvalid", 64'(core_rvalid_o), 64'd0);
      else begin
        e = q.pop_front();
        chk("rel_cycle", 64'(cyc), 64'(e.cyc));
        chk("rel_data", 64'(core_rdata_o), 64'(e.data));
        chk("rel_err", 64'(core_err_o), 64'(e.err));
      end
    end
  end

  // Drive one response this cycle; the model predicts when it comes back.
  task automatic send(input logic [31:0] data, input logic err, input bit record);
    exp_t   x;
    longint d;
    d = 0;
    if (en_stall_i && stall_mode_i == 32'd1) d = rvalid_stall_i[15:0];
    else if (en_stall_i && stall_mode_i == 32'd2) begin
      d = lfsr_m[15:0] % (max_stall_i[15:0] + 32'd1);
      if (record)
        lfsr_m = {1'b0, lfsr_m[31:1]} ^ ({32{lfsr_m[0]}} & 32'h8020_0003);
    end
    x.data = data;
    x.err  = err;
    if (!en_stall_i && q.size() == 0) x.cyc = cyc;
    else begin
      x.cyc = cyc + 1 + d;
      if (x.cyc <= last_rel) x.cyc = last_rel + 1;
      last_rel = x.cyc;
    end
    if (record) q.push_back(x);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    mem_err_i    = err;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin idle(1); k++; end
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    #2;
    chk({tag, "_rvalid"}, 64'(core_rvalid_o), 64'd0);
    chk({tag, "_rdata"}, 64'(core_rdata_o), 64'd0);
    chk({tag, "_outst"}, 64'(outstanding_o), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
    q.delete();
    lfsr_m   = SEED;
    last_rel = -1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_ni = 1'b0; en_stall_i = 1'b0; stall_mode_i = '0; max_stall_i = '0;
    rvalid_stall_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    idle(2);
    do_reset("reset");

    // Bypass: same-cycle pass-through, nothing buffered.
    send(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("bypass_outst", 64'(outstanding_o), 64'd0);
    idle(2);
    chk("bypass_drain", 64'(q.size()), 64'd0);

    // Fixed delay 3, error propagated.
    en_stall_i = 1'b1; stall_mode_i = 32'd1; rvalid_stall_i = 32'd3;
    send(32'h1234_5678, 1'b1, 1'b1);
    chk("std_outst", 64'(outstanding_o), 64'd1);
    drain("std_drain", 20);

    // Back-to-back with d = 2.
    rvalid_stall_i = 32'd2;
    send(32'hA, 1'b0, 1'b1);
    send(32'hB, 1'b1, 1'b1);
    send(32'hC, 1'b0, 1'b1);
    drain("b2b_drain", 20);

    // Short-delay entry must wait behind a longer head.
    rvalid_stall_i = 32'd5;
    send(32'hAAAA, 1'b0, 1'b1);
    rvalid_stall_i = 32'd0;
    send(32'hBBBB, 1'b0, 1'b1);
    drain("order_drain", 20);

    // Overflow: ninth response dropped, sticky flag.
    rvalid_stall_i = 32'd20;
    for (int i = 0; i < 8; i++) send(32'h100 + i, 1'b0, 1'b1);
    chk("full_outst", 64'(outstanding_o), 64'd8);
    chk("pre_ovf", 64'(overflow_o), 64'd0);
    send(32'h1FF, 1'b1, 1'b0);
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("ovf_outst", 64'(outstanding_o), 64'd8);
    drain("ovf_drain", 60);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    chk("ovf_empty", 64'(outstanding_o), 64'd0);
    do_reset("ovf_reset");

    // Random delays with a reset in the middle of the burst.
    stall_mode_i = 32'd2; max_stall_i = 32'd4;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, 1'($urandom_range(0, 1)), 1'b1);
      idle($urandom_range(0, 2));
      if (i == 600) do_reset("mid_reset");
    end
    drain("rnd_drain", 200);
    chk("rnd_ovf", 64'(overflow_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
